// File: rtl/f3m_trit_deser_pkg.sv
// Shared GF(3) constants: trit codes, element/counter widths and the deserializer state encoding.
package f3m_trit_deser_pkg;

   localparam int unsigned TRIT_W = 2;

   localparam logic [1:0] TRIT_ZERO = 2'b00;
   localparam logic [1:0] TRIT_ONE  = 2'b01;
   localparam logic [1:0] TRIT_TWO  = 2'b10;
   localparam logic [1:0] TRIT_BAD  = 2'b11;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_FULL    = 1'b1
   } state_e;

   function automatic int unsigned elem_w(input int unsigned m);
      return TRIT_W * m;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/f3m_trit_deser_f3_sub.sv
// GF(3) subtraction of two valid trit codes: d = a - b mod 3.
module f3m_trit_deser_f3_sub
   import f3m_trit_deser_pkg::*;
(
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [1:0] d
);

   logic [2:0] s;

   // Bias by 3 so the difference never goes negative, then fold back into 0..2.
   always_comb begin
      s = 3'(3'd3 + {1'b0, a} - {1'b0, b});
      d = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   end

endmodule

// File: rtl/f3m_trit_deser.sv
// Trit-serial to GF(3^M) element deserializer with negate-on-load and sticky invalid-code flag.
module f3m_trit_deser
   import f3m_trit_deser_pkg::*;
#(
   parameter int unsigned M = 97
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   neg_in,
   input  logic                   in_valid,
   input  logic [1:0]             in_trit,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [elem_w(M)-1:0]   out_data,
   output logic                   out_err
);

   localparam int unsigned EW = elem_w(M);
   localparam int unsigned CW = cnt_w(M);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_q;

   logic            accept;
   logic            bad;
   logic            first;
   logic            last;
   logic            neg_now;
   logic [1:0]      clean;
   logic [1:0]      neg_trit;
   logic [1:0]      stored;
   logic [EW-1:0]   data_nxt;

   f3m_trit_deser_f3_sub u_neg (
      .a (TRIT_ZERO),
      .b (clean),
      .d (neg_trit)
   );

   // Sanitize, optionally negate and place the incoming trit into the element.
   always_comb begin
      accept   = in_valid & in_ready;
      bad      = (in_trit == TRIT_BAD);
      clean    = bad ? TRIT_ZERO : in_trit;
      first    = (cnt_q == '0);
      last     = (cnt_q == CW'(M - 1));
      neg_now  = first ? neg_in : neg_q;
      stored   = neg_now ? neg_trit : clean;
      data_nxt = first ? '0 : out_data;
      for (int unsigned i = 0; i < M; i++) begin
         if (cnt_q == CW'(i)) data_nxt[2*i +: 2] = stored;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_COLLECT;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         out_err   <= 1'b0;
         out_data  <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else if (clear) begin
         state_q   <= ST_COLLECT;
         cnt_q     <= '0;
         out_err   <= 1'b0;
         out_data  <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (accept) begin
                  out_data <= data_nxt;
                  if (first) begin
                     neg_q   <= neg_in;
                     out_err <= bad;
                  end else begin
                     out_err <= out_err | bad;
                  end
                  if (last) begin
                     cnt_q     <= '0;
                     state_q   <= ST_FULL;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            ST_FULL: begin
               // Release only; the freed slot takes its first trit next cycle.
               if (out_ready) begin
                  state_q   <= ST_COLLECT;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_COLLECT;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_f3m_trit_deser.sv
// Directed and randomized-gap checks of the trit deserializer against a small bench-side model.
module tb_f3m_trit_deser;

   localparam int unsigned M  = 97;
   localparam int unsigned EW = 2 * M;
   localparam int unsigned NR = 200;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear = 1'b0;
   logic          neg_in = 1'b0;
   logic          in_valid = 1'b0;
   logic [1:0]    in_trit = 2'b00;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [EW-1:0] out_data;
   logic          out_err;

   int checks = 0;
   int errors = 0;

   logic [1:0] tv [M];

   f3m_trit_deser #(.M(M)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .neg_in    (neg_in),
      .in_valid  (in_valid),
      .in_trit   (in_trit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [1:0] model_trit(input logic [1:0] t, input logic n);
      logic [1:0] v;
      v = (t == 2'b11) ? 2'b00 : t;
      if (n) begin
         case (v)
            2'b01:   v = 2'b10;
            2'b10:   v = 2'b01;
            default: v = 2'b00;
         endcase
      end
      return v;
   endfunction

   function automatic logic [EW-1:0] model_elem(input logic n);
      logic [EW-1:0] r;
      r = '0;
      for (int i = 0; i < M; i++) r[2*i +: 2] = model_trit(tv[i], n);
      return r;
   endfunction

   function automatic logic model_err();
      logic e;
      e = 1'b0;
      for (int i = 0; i < M; i++) if (tv[i] == 2'b11) e = 1'b1;
      return e;
   endfunction

   task automatic fill_pattern(input int offs);
      for (int k = 0; k < M; k++) tv[k] = 2'((k + 1 + offs) % 3);
   endtask

   // Offer one trit from a negedge and hold it until the DUT takes it.
   task automatic push(input logic [1:0] t, input logic n);
      int g;
      g = 0;
      in_valid = 1'b1;
      in_trit  = t;
      neg_in   = n;
      while (!in_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         checks++; errors++;
         $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_elem(input string nm, input logic n);
      for (int k = 0; k < M - 1; k++) push(tv[k], (k == 0) ? n : ~n);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL %s_early_valid: got %b exp 0", nm, out_valid);
      end
      push(tv[M-1], ~n);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL %s_latency: valid %b ready %b exp 1 0", nm, out_valid, in_ready);
      end
      checks++;
      if (out_data !== model_elem(n)) begin
         errors++; $display("FAIL %s_data: got %h exp %h", nm, out_data, model_elem(n));
      end
      checks++;
      if (out_err !== model_err()) begin
         errors++; $display("FAIL %s_err: got %b exp %b", nm, out_err, model_err());
      end
   endtask

   task automatic pop(input string nm);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL %s_pop: valid %b ready %b exp 0 1", nm, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid %b ready %b data %h err %b exp 0 1 0 0",
                  out_valid, in_ready, out_data, out_err);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release: valid %b ready %b exp 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_basic();
      fill_pattern(0);
      send_elem("basic", 1'b0);
      checks++;
      if (out_data[5:0] !== 6'b00_10_01) begin
         errors++; $display("FAIL basic_low_trits: got %b exp 001001", out_data[5:0]);
      end
      pop("basic");
   endtask

   task automatic test_neg();
      fill_pattern(0);
      send_elem("neg", 1'b1);
      checks++;
      if (out_data[5:0] !== 6'b00_01_10) begin
         errors++; $display("FAIL neg_low_trits: got %b exp 000110", out_data[5:0]);
      end
      pop("neg");
   endtask

   task automatic test_err();
      fill_pattern(0);
      tv[5] = 2'b11;
      send_elem("err", 1'b0);
      checks++;
      if (out_data[11:10] !== 2'b00 || out_err !== 1'b1) begin
         errors++; $display("FAIL err_invalid: trit5 %b err %b exp 00 1", out_data[11:10], out_err);
      end
      pop("err");
      fill_pattern(1);
      send_elem("err_clean", 1'b0);
      checks++;
      if (out_err !== 1'b0) begin
         errors++; $display("FAIL err_sticky_clear: got %b exp 0", out_err);
      end
      pop("err_clean");
   endtask

   task automatic test_back_to_back();
      logic [EW-1:0] snap;
      logic [EW-1:0] e1;
      fill_pattern(2);
      send_elem("bp", 1'b0);
      snap     = model_elem(1'b0);
      in_valid = 1'b1;
      in_trit  = 2'b10;
      neg_in   = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== snap) begin
            errors++;
            $display("FAIL bp_hold cyc %0d: ready %b valid %b data %h exp 0 1 %h",
                     c, in_ready, out_valid, out_data, snap);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== snap) begin
         errors++; $display("FAIL bp_release: ready %b valid %b exp 1 0 data unchanged", in_ready, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      e1 = '0;
      e1[1:0] = 2'b10;
      checks++;
      if (out_data !== e1) begin
         errors++; $display("FAIL bp_first_trit: got %h exp %h", out_data, e1);
      end
      fill_pattern(0);
      tv[0] = 2'b10;
      for (int k = 1; k < M; k++) push(tv[k], 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== model_elem(1'b0)) begin
         errors++; $display("FAIL bp_next_elem: valid %b data %h exp 1 %h", out_valid, out_data, model_elem(1'b0));
      end
      pop("bp");
   endtask

   task automatic test_clear();
      fill_pattern(1);
      tv[3] = 2'b11;
      for (int k = 0; k < 40; k++) push(tv[k], 1'b1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_trit  = 2'b01;
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL clear_state: ready %b valid %b err %b data %h exp 1 0 0 0",
                  in_ready, out_valid, out_err, out_data);
      end
      fill_pattern(0);
      send_elem("clear_next", 1'b0);
      pop("clear_next");
   endtask

   task automatic test_reset_mid();
      fill_pattern(2);
      for (int k = 0; k < 30; k++) push(tv[k], 1'b0);
      reset = 1'b1;
      #1;
      checks++;
      if (out_data !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mid_async: data %h ready %b valid %b exp 0 1 0", out_data, in_ready, out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      fill_pattern(1);
      send_elem("reset_next", 1'b1);
      pop("reset_next");
   endtask

   task automatic test_random();
      logic [EW-1:0] q_d [$];
      logic          q_e [$];
      logic [EW-1:0] ed;
      logic          ee;
      logic          cur_neg;
      logic          acc, hs;
      int idx, prod, popped, acc_cnt, cyc, r;
      idx = 0; prod = 0; popped = 0; acc_cnt = 0; cyc = 0;
      for (int k = 0; k < M; k++) begin
         r = int'($urandom_range(0, 15));
         tv[k] = (r == 0) ? 2'b11 : 2'(r % 3);
      end
      cur_neg = 1'($urandom_range(0, 1));
      while (popped < int'(NR) && cyc < 60000) begin
         in_valid  = (prod < int'(NR)) && ($urandom_range(0, 3) != 0);
         in_trit   = tv[idx];
         neg_in    = (idx == 0) ? cur_neg : 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         if (hs) begin
            checks++;
            if (q_d.size() == 0) begin
               errors++; $display("FAIL rand_unexpected_elem: got %h with empty model queue", out_data);
            end else begin
               ed = q_d.pop_front();
               ee = q_e.pop_front();
               if (out_data !== ed || out_err !== ee || acc_cnt != int'(M)) begin
                  errors++;
                  $display("FAIL rand_elem %0d: data %h err %b trits %0d exp %h %b %0d",
                           popped, out_data, out_err, acc_cnt, ed, ee, M);
               end
            end
            acc_cnt = 0;
            popped++;
         end
         if (acc) begin
            acc_cnt++;
            idx++;
            if (idx == int'(M)) begin
               q_d.push_back(model_elem(cur_neg));
               q_e.push_back(model_err());
               prod++;
               idx = 0;
               for (int k = 0; k < M; k++) begin
                  r = int'($urandom_range(0, 15));
                  tv[k] = (r == 0) ? 2'b11 : 2'(r % 3);
               end
               cur_neg = 1'($urandom_range(0, 1));
            end
         end
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (popped != int'(NR)) begin
         errors++; $display("FAIL rand_timeout: popped %0d exp %0d", popped, NR);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_neg();
      test_err();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
